uart_rx: RTL and testbench

// - UART receiver: the counterpart of the transmitter. It turns the serial line back

---
 rtl/uart_rx_if.sv | 20 ++
 rtl/uart_rx.sv | 163 ++++++++++++++++
 tb/tb_uart_rx.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Byte-side bundle of the UART receiver: valid/ready holding register plus error pulses.
// master = receiver side, slave = downstream consumer.
interface uart_rx_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       parity_err;

  modport master (
    output rx_data, rx_valid, frame_err, overrun, parity_err,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, frame_err, overrun, parity_err,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: oversampled UART receiver (8N1), mid-bit sampling, glitch/frame/overrun checks.
// Define UART_RX_PARITY_EN to add a parity bit (8E1/8O1 selected by PARITY_ODD).
module uart_rx #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      rx,
  uart_rx_if.master bus
);

  localparam int TICK_DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int TCNT_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SCNT_W   = $clog2(OVERSAMPLE);

  localparam logic [TCNT_W-1:0] TICK_LAST = TCNT_W'(TICK_DIV - 1);
  localparam logic [SCNT_W-1:0] SAMP_MID  = SCNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SCNT_W-1:0] SAMP_LAST = SCNT_W'(OVERSAMPLE - 1);

  if (TICK_DIV < 1 || OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0 ||
      PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_param_check
    $error("uart_rx: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_t;

  state_t state, state_nxt;

  logic              rx_meta_p0, rx_s, rx_s_d;
  logic              fall, tick;
  logic [TCNT_W-1:0] tick_cnt;
  logic [SCNT_W-1:0] samp_cnt, samp_target;
  logic [2:0]        bit_cnt;
  logic [7:0]        shift_p0;
  logic              start_entry, sample, shift_en, stop_ok, stop_bad;
  logic              par_ok, commit, par_fail;

  // Stage 0/1: two-flop synchroniser, then edge-detect delay
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_p0 <= 1'b1;
      rx_s       <= 1'b1;
      rx_s_d     <= 1'b1;
    end else begin
      rx_meta_p0 <= rx;
      rx_s       <= rx_meta_p0;
      rx_s_d     <= rx_s;
    end
  end

  assign fall = rx_s_d & ~rx_s;
  assign tick = (tick_cnt == TICK_LAST);

  // Tick divider restarts on START entry so the first sample lands mid start-bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       tick_cnt <= '0;
    else if (start_entry || tick)  tick_cnt <= '0;
    else                           tick_cnt <= tick_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     samp_cnt <= '0;
    else if (start_entry)        samp_cnt <= '0;
    else if (tick && state != S_IDLE && state != S_BREAK)
      samp_cnt <= sample ? '0 : samp_cnt + 1'b1;
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (fall)   state_nxt = S_START;
      S_START:  if (sample) state_nxt = rx_s ? S_IDLE : S_DATA;
      S_DATA:
        if (sample && bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
          state_nxt = S_PARITY;
`else
          state_nxt = S_STOP;
`endif
        end
      S_PARITY: if (sample) state_nxt = S_STOP;
      S_STOP:   if (sample) state_nxt = rx_s ? S_IDLE : S_BREAK;
      S_BREAK:  if (rx_s)   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // FSM output decode
  always_comb begin
    start_entry = (state == S_IDLE) && fall;
    samp_target = (state == S_START) ? SAMP_MID : SAMP_LAST;
    sample      = tick && (samp_cnt == samp_target) &&
                  (state == S_START || state == S_DATA ||
                   state == S_PARITY || state == S_STOP);
    shift_en    = sample && (state == S_DATA);
    stop_ok     = sample && (state == S_STOP) && rx_s;
    stop_bad    = sample && (state == S_STOP) && !rx_s;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt  <= '0;
      shift_p0 <= '0;
    end else if (start_entry) begin
      bit_cnt  <= '0;
    end else if (shift_en) begin
      bit_cnt  <= bit_cnt + 1'b1;
      shift_p0 <= {rx_s, shift_p0[7:1]};
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_en, par_bit_p0;

  assign par_en = sample && (state == S_PARITY);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         par_bit_p0 <= 1'b0;
    else if (par_en) par_bit_p0 <= rx_s;
  end

  assign par_ok = (par_bit_p0 == ((^shift_p0) ^ 1'(PARITY_ODD)));
`else
  assign par_ok = 1'b1;
`endif

  assign commit   = stop_ok && par_ok;
  assign par_fail = stop_ok && !par_ok;

  // Stage 2: holding register and one-cycle error pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.rx_data    <= '0;
      bus.rx_valid   <= 1'b0;
      bus.frame_err  <= 1'b0;
      bus.overrun    <= 1'b0;
      bus.parity_err <= 1'b0;
    end else begin
      bus.frame_err  <= stop_bad;
      bus.parity_err <= par_fail;
      bus.overrun    <= commit && bus.rx_valid && !bus.rx_ready;
      if (commit && (!bus.rx_valid || bus.rx_ready)) begin
        bus.rx_data  <= shift_p0;
        bus.rx_valid <= 1'b1;
      end else if (bus.rx_valid && bus.rx_ready) begin
        bus.rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at 16 clk/bit: vector table, hand-written corner sequences and
// randomized frames checked against a frame-level model of the holding register.
module tb_uart_rx;

  localparam int BIT_CLK = 16;
`ifdef UART_RX_PARITY_EN
  localparam int PAR_ODD = 1;
`else
  localparam int PAR_ODD = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic rx;

  uart_rx_if bus ();

  uart_rx #(
    .CLK_FREQ  (16000000),
    .BAUD_RATE (1000000),
    .OVERSAMPLE(16),
    .PARITY_ODD(PAR_ODD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx (rx),
    .bus(bus.master)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Event counters observed on the byte side
  int         c_xfer = 0, c_vcyc = 0, c_ferr = 0, c_ovr = 0, c_perr = 0;
  logic [7:0] last_xfer = 8'h00;

  always @(negedge clk) begin
    if (bus.rx_valid) c_vcyc <= c_vcyc + 1;
    if (bus.rx_valid && bus.rx_ready) begin
      c_xfer    <= c_xfer + 1;
      last_xfer <= bus.rx_data;
    end
    if (bus.frame_err)  c_ferr <= c_ferr + 1;
    if (bus.overrun)    c_ovr  <= c_ovr + 1;
    if (bus.parity_err) c_perr <= c_perr + 1;
  end

  int s_xfer, s_vcyc, s_ferr, s_ovr, s_perr;

  task automatic snap();
    s_xfer = c_xfer; s_vcyc = c_vcyc; s_ferr = c_ferr; s_ovr = c_ovr; s_perr = c_perr;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clk_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    clk_n(BIT_CLK);
  endtask

`ifdef UART_RX_PARITY_EN
  function automatic logic par_of(input logic [7:0] d);
    return (^d) ^ 1'(PAR_ODD);
  endfunction
`endif

  task automatic send_frame(input logic [7:0] d, input bit stop, input bit flip);
    send_bit(1'b0);
    for (int b = 0; b < 8; b++) send_bit(d[b]);
`ifdef UART_RX_PARITY_EN
    send_bit(par_of(d) ^ flip);
`else
    if (flip) $display("note: parity flip ignored without parity build");
`endif
    send_bit(stop);
  endtask

  task automatic check_deltas(input string tag, input int ex, input int ef,
                              input int eo, input int ep);
    check({tag, " xfer"},      c_xfer - s_xfer, ex);
    check({tag, " frame_err"}, c_ferr - s_ferr, ef);
    check({tag, " overrun"},   c_ovr  - s_ovr,  eo);
    check({tag, " parity"},    c_perr - s_perr, ep);
  endtask

  typedef struct {
    logic [7:0] data;
    bit         stop;
    bit         flip;
    int         exp_xfer;
    int         exp_ferr;
    int         exp_perr;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       v;
    bit         full;
    logic [7:0] held;
    logic [7:0] d;
    bit         stop, flip, rdy;
    int         ex, ef, eo, ep;

    vecs.push_back('{8'hA5, 1'b1, 1'b0, 1, 0, 0});
    vecs.push_back('{8'h3C, 1'b0, 1'b0, 0, 1, 0});
    vecs.push_back('{8'h00, 1'b1, 1'b0, 1, 0, 0});
    vecs.push_back('{8'hFF, 1'b1, 1'b0, 1, 0, 0});
    vecs.push_back('{8'h80, 1'b1, 1'b0, 1, 0, 0});
    vecs.push_back('{8'h01, 1'b0, 1'b0, 0, 1, 0});
`ifdef UART_RX_PARITY_EN
    vecs.push_back('{8'h01, 1'b1, 1'b1, 0, 0, 1});
    vecs.push_back('{8'h01, 1'b1, 1'b0, 1, 0, 0});
    vecs.push_back('{8'hC3, 1'b1, 1'b1, 0, 0, 1});
`endif

    rst = 1'b1; rx = 1'b1; bus.rx_ready = 1'b0;
    clk_n(3);
    check("reset rx_valid",   bus.rx_valid,   0);
    check("reset rx_data",    bus.rx_data,    0);
    check("reset frame_err",  bus.frame_err,  0);
    check("reset overrun",    bus.overrun,    0);
    check("reset parity_err", bus.parity_err, 0);
    rst = 1'b0;
    clk_n(20);

    foreach (vecs[i]) begin
      v = vecs[i];
      bus.rx_ready = 1'b1;
      clk_n(3);
      snap();
      send_frame(v.data, v.stop, v.flip);
      rx = 1'b1;
      clk_n(40);
      check_deltas($sformatf("vec%0d", i), v.exp_xfer, v.exp_ferr, 0, v.exp_perr);
      check($sformatf("vec%0d valid cycles", i), c_vcyc - s_vcyc, v.exp_xfer);
      if (v.exp_xfer == 1) check($sformatf("vec%0d data", i), last_xfer, v.data);
    end

    // Short low pulse must be rejected as a glitch, then a real frame decodes
    snap();
    rx = 1'b0; clk_n(4); rx = 1'b1; clk_n(40);
    check_deltas("glitch", 0, 0, 0, 0);
    check("glitch valid cycles", c_vcyc - s_vcyc, 0);
    send_frame(8'h5A, 1'b1, 1'b0); clk_n(40);
    check("after glitch xfer", c_xfer - s_xfer, 1);
    check("after glitch data", last_xfer, 8'h5A);

    // Framing error followed by a long break, then recovery
    snap();
    send_frame(8'h3C, 1'b0, 1'b0);
    clk_n(200);
    rx = 1'b1; clk_n(32);
    check("break frame_err", c_ferr - s_ferr, 1);
    check("break no xfer", c_xfer - s_xfer, 0);
    send_frame(8'h55, 1'b1, 1'b0); clk_n(40);
    check_deltas("break recov", 1, 1, 0, 0);
    check("break recov data", last_xfer, 8'h55);

    // Back-to-back frames into a stalled consumer
    bus.rx_ready = 1'b0;
    clk_n(3);
    snap();
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    clk_n(40);
    check("ovr rx_valid", bus.rx_valid, 1);
    check("ovr rx_data",  bus.rx_data,  8'h11);
    check_deltas("ovr", 0, 0, 1, 0);
    bus.rx_ready = 1'b1;
    clk_n(1);
    bus.rx_ready = 1'b0;
    check("ovr drained rx_valid", bus.rx_valid, 0);
    check("ovr drained data", last_xfer, 8'h11);

    // Async reset mid-frame with a byte held in the register
    send_frame(8'h42, 1'b1, 1'b0); clk_n(40);
    check("pre-reset rx_valid", bus.rx_valid, 1);
    send_bit(1'b0);
    for (int b = 0; b < 4; b++) send_bit(1'(8'h7E >> b));
    #3 rst = 1'b1;
    #1;
    check("mid reset rx_valid",   bus.rx_valid,   0);
    check("mid reset rx_data",    bus.rx_data,    0);
    check("mid reset frame_err",  bus.frame_err,  0);
    check("mid reset overrun",    bus.overrun,    0);
    check("mid reset parity_err", bus.parity_err, 0);
    rx = 1'b1;
    clk_n(2);
    rst = 1'b0;
    clk_n(20);
    bus.rx_ready = 1'b1;
    snap();
    send_frame(8'h7E, 1'b1, 1'b0); clk_n(40);
    check_deltas("post reset", 1, 0, 0, 0);
    check("post reset data", last_xfer, 8'h7E);

    // Randomized frames against a frame-level holding-register model
    full = 1'b0;
    held = 8'h00;
    for (int i = 0; i < 16; i++) begin
      d    = 8'($urandom);
      stop = ($urandom_range(0, 5) != 0);
`ifdef UART_RX_PARITY_EN
      flip = ($urandom_range(0, 4) == 0);
`else
      flip = 1'b0;
`endif
      rdy  = 1'($urandom_range(0, 1));
      bus.rx_ready = rdy;
      clk_n(3);
      if (rdy) full = 1'b0;
      snap();
      send_frame(d, stop, flip);
      rx = 1'b1;
      clk_n(40);
      ex = 0; ef = 0; eo = 0; ep = 0;
      if (!stop)             ef = 1;
      else if (flip)         ep = 1;
      else if (full && !rdy) eo = 1;
      else if (rdy)          ex = 1;
      else begin
        full = 1'b1;
        held = d;
      end
      check_deltas($sformatf("rnd%0d", i), ex, ef, eo, ep);
      check($sformatf("rnd%0d rx_valid", i), bus.rx_valid, full);
      if (ex == 1) check($sformatf("rnd%0d xfer data", i), last_xfer, d);
      if (full)    check($sformatf("rnd%0d held data", i), bus.rx_data, held);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
